// File: rtl/adc_capture_ctrl_pkg.sv
// Shared encodings for the ADC capture sequencer: FSM states and trigger modes.
package adc_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_OFFSET  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [1:0] TRIG_RISE = 2'd0;
  localparam logic [1:0] TRIG_FALL = 2'd1;
  localparam logic [1:0] TRIG_HIGH = 2'd2;
  localparam logic [1:0] TRIG_LOW  = 2'd3;

endpackage

// File: rtl/adc_capture_ctrl_trig_qualify.sv
// Trigger qualifier: synchronises the raw trigger, detects edges, selects the
// configured condition and ORs in the software trigger.
module trig_qualify
  import adc_capture_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       trigger_i,
  input  logic [1:0] mode_i,
  input  logic       trigger_now_i,
  output logic       qual_o
);

  logic sync1_q, sync2_q, sync3_q;
  logic qual_q;
  logic cond_d;

  // Mode mux on the synchronised value; edge modes compare against the third flop.
  always_comb begin
    cond_d = 1'b0;
    case (mode_i)
      TRIG_RISE: cond_d = sync2_q & ~sync3_q;
      TRIG_FALL: cond_d = ~sync2_q & sync3_q;
      TRIG_HIGH: cond_d = sync2_q;
      TRIG_LOW:  cond_d = ~sync2_q;
      default:   cond_d = 1'b0;
    endcase
  end

  // Two-flop synchroniser, edge-detect flop and registered condition (3-cycle latency).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      qual_q  <= 1'b0;
    end else begin
      sync1_q <= trigger_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      qual_q  <= cond_d;
    end
  end

  // The software trigger is already synchronous, so it bypasses the pipeline.
  assign qual_o = qual_q | trigger_now_i;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Arm/trigger sequencer feeding the sample FIFO stage: waits for a qualified
// trigger, delays by a programmable offset, runs the capture until stopped.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int OFFSET_W  = 32,
  parameter int TRIGCNT_W = 16
) (
  input  logic                 adc_sampleclk,
  input  logic                 reset_i,
  input  logic                 arm_i,
  input  logic                 trigger_i,
  input  logic [1:0]           trigger_mode_i,
  input  logic                 trigger_now_i,
  input  logic [OFFSET_W-1:0]  trigger_offset_i,
  input  logic                 adc_capture_stop,
  output logic                 adc_capture_go,
  output logic                 adc_capture_armed,
  output logic                 adc_trig_status,
  output logic                 capture_done_o,
  output logic [TRIGCNT_W-1:0] trig_count_o
);

  state_e               state_q, state_d;
  logic                 arm_q;
  logic                 arm_rise;
  logic                 qual;
  logic                 count_en;
  logic [OFFSET_W-1:0]  off_cnt_q, off_cnt_d;
  logic [TRIGCNT_W-1:0] trig_cnt_q, trig_cnt_d;
  logic                 status_q, status_d;

  trig_qualify u_trig_qualify (
    .clk_i         (adc_sampleclk),
    .rst_i         (reset_i),
    .trigger_i     (trigger_i),
    .mode_i        (trigger_mode_i),
    .trigger_now_i (trigger_now_i),
    .qual_o        (qual)
  );

  assign arm_rise = arm_i & ~arm_q;
  assign count_en = (state_q == ST_ARMED) || (state_q == ST_OFFSET) ||
                    (state_q == ST_CAPTURE);

  // Next-state logic plus offset counter, trigger counter and sticky status.
  always_comb begin
    state_d    = state_q;
    off_cnt_d  = off_cnt_q;
    trig_cnt_d = trig_cnt_q;
    status_d   = status_q;
    if (count_en && qual && (trig_cnt_q != {TRIGCNT_W{1'b1}}))
      trig_cnt_d = trig_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Arming wins over a coincident trigger: nothing is counted here.
        if (arm_rise) begin
          state_d    = ST_ARMED;
          trig_cnt_d = '0;
          status_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (!arm_i) begin
          state_d  = ST_IDLE;
          status_d = 1'b0;
        end else if (qual) begin
          status_d = 1'b1;
          if (trigger_offset_i == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d   = ST_OFFSET;
            off_cnt_d = trigger_offset_i;
          end
        end
      end
      ST_OFFSET: begin
        // Further triggers here only bump the count; the offset keeps running.
        off_cnt_d = off_cnt_q - 1'b1;
        if (!arm_i) begin
          state_d  = ST_IDLE;
          status_d = 1'b0;
        end else if (off_cnt_q == OFFSET_W'(1)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Dropping arm does not abort a running capture; only stop ends it.
        if (adc_capture_stop) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, arm-edge and counter registers.
  always_ff @(posedge adc_sampleclk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      arm_q      <= 1'b0;
      off_cnt_q  <= '0;
      trig_cnt_q <= '0;
      status_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_i;
      off_cnt_q  <= off_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      status_q   <= status_d;
    end
  end

  assign adc_capture_go    = (state_q == ST_CAPTURE);
  assign adc_capture_armed = (state_q == ST_ARMED) || (state_q == ST_OFFSET);
  assign capture_done_o    = (state_q == ST_DONE);
  assign adc_trig_status   = status_q;
  assign trig_count_o      = trig_cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a per-cycle vector table for the
// software-trigger/arm sequencing plus hand-written multi-cycle sequences.
module tb_adc_capture_ctrl;
  import adc_capture_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i, arm_i, trigger_i, trigger_now_i, stop;
  logic [1:0]  mode;
  logic [31:0] offset;
  logic        go, armed, status, done;
  logic [15:0] cnt;
  logic        go4, armed4, status4, done4;
  logic [3:0]  cnt4;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.OFFSET_W(32), .TRIGCNT_W(16)) dut (
    .adc_sampleclk(clk), .reset_i(reset_i), .arm_i(arm_i), .trigger_i(trigger_i),
    .trigger_mode_i(mode), .trigger_now_i(trigger_now_i), .trigger_offset_i(offset),
    .adc_capture_stop(stop), .adc_capture_go(go), .adc_capture_armed(armed),
    .adc_trig_status(status), .capture_done_o(done), .trig_count_o(cnt)
  );

  adc_capture_ctrl #(.OFFSET_W(32), .TRIGCNT_W(4)) dut4 (
    .adc_sampleclk(clk), .reset_i(reset_i), .arm_i(arm_i), .trigger_i(trigger_i),
    .trigger_mode_i(mode), .trigger_now_i(trigger_now_i), .trigger_offset_i(offset),
    .adc_capture_stop(stop), .adc_capture_go(go4), .adc_capture_armed(armed4),
    .adc_trig_status(status4), .capture_done_o(done4), .trig_count_o(cnt4)
  );

  typedef struct {
    logic        arm;
    logic        now;
    logic        stp;
    logic        e_go;
    logic        e_armed;
    logic        e_status;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: reset was high at the preceding edge.
  task automatic do_reset();
    reset_i = 1'b1; arm_i = 1'b0; trigger_i = 1'b0; trigger_now_i = 1'b0; stop = 1'b0;
    repeat (4) next_cyc();
    reset_i = 1'b0;
  endtask

  int rises;
  logic prev_go;

  initial begin
    // Row i: inputs driven during cycle i; expectations are the outputs seen in cycle i.
    //            arm   now   stop  go    armed stat  done  cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    // Software trigger, spurious stop, re-arm from DONE, abort, arm+trigger in IDLE.
    mode = TRIG_RISE; offset = 32'd0;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      arm_i = tbl[i].arm; trigger_now_i = tbl[i].now; stop = tbl[i].stp;
      @(negedge clk);
      check($sformatf("vec%0d go", i),     go,     tbl[i].e_go);
      check($sformatf("vec%0d armed", i),  armed,  tbl[i].e_armed);
      check($sformatf("vec%0d status", i), status, tbl[i].e_status);
      check($sformatf("vec%0d done", i),   done,   tbl[i].e_done);
      check($sformatf("vec%0d count", i),  cnt,    tbl[i].e_cnt);
      next_cyc();
    end

    // Rising edge, offset 0: trigger at 10 -> go at 14, stop at 40 -> DONE at 41.
    mode = TRIG_RISE; offset = 32'd0;
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      arm_i = (c >= 1); trigger_i = (c >= 10); stop = (c == 40);
      @(negedge clk);
      check($sformatf("rise c%0d go", c),    go,    (c >= 14 && c <= 40));
      check($sformatf("rise c%0d armed", c), armed, (c >= 2 && c <= 13));
      if (c == 13) check("rise status before", status, 0);
      if (c == 14) check("rise status set", status, 1);
      if (c == 41) begin
        check("rise done", done, 1);
        check("rise count", cnt, 1);
      end
      next_cyc();
    end

    // Offset 100: qualify at 13 -> go at 114, armed held through OFFSET.
    mode = TRIG_RISE; offset = 32'd100;
    do_reset();
    for (int c = 0; c <= 120; c++) begin
      arm_i = (c >= 1); trigger_i = (c >= 10); stop = 1'b0;
      @(negedge clk);
      check($sformatf("ofs c%0d go", c),    go,    (c >= 114));
      check($sformatf("ofs c%0d armed", c), armed, (c >= 2 && c < 114));
      if (c == 114) check("ofs count", cnt, 1);
      next_cyc();
    end

    // High level for 5 cycles, offset 10: five counts, a single capture.
    mode = TRIG_HIGH; offset = 32'd10;
    do_reset();
    rises = 0; prev_go = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      arm_i = (c >= 1); trigger_i = (c >= 10 && c <= 14); stop = (c == 40);
      @(negedge clk);
      if (go && !prev_go) rises++;
      prev_go = go;
      if (c == 23) check("lvl go early", go, 0);
      if (c == 24) check("lvl go", go, 1);
      if (c == 30) begin
        check("lvl count", cnt, 5);
        check("lvl count w4", cnt4, 5);
      end
      if (c == 41) check("lvl done", done, 1);
      next_cyc();
    end
    check("lvl capture count", rises, 1);

    // High level for 20 cycles: the 4-bit counter saturates at 15 without wrapping.
    mode = TRIG_HIGH; offset = 32'd10;
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      arm_i = (c >= 1); trigger_i = (c >= 10 && c <= 29); stop = 1'b0;
      @(negedge clk);
      if (c == 27) check("sat w4 c27", cnt4, 14);
      if (c == 28) check("sat w4 c28", cnt4, 15);
      if (c == 35) begin
        check("sat w4 hold", cnt4, 15);
        check("sat w16", cnt, 20);
      end
      next_cyc();
    end

    // Abort in OFFSET (offset 1000), then re-arm and capture normally.
    mode = TRIG_RISE; offset = 32'd1000;
    do_reset();
    for (int c = 0; c <= 80; c++) begin
      arm_i = (c >= 1 && c < 50) || (c >= 60);
      trigger_i = (c >= 10 && c < 55) || (c >= 70);
      stop = 1'b0;
      if (c == 60) offset = 32'd0;
      @(negedge clk);
      check($sformatf("abort c%0d go", c), go, (c >= 74));
      if (c == 49) check("abort armed in offset", armed, 1);
      if (c == 51) begin
        check("abort armed", armed, 0);
        check("abort status", status, 0);
        check("abort count kept", cnt, 1);
      end
      if (c == 61) begin
        check("rearm armed", armed, 1);
        check("rearm count clear", cnt, 0);
      end
      if (c == 74) check("rearm count", cnt, 1);
      next_cyc();
    end

    // Reset during CAPTURE: go and armed low on the first cycle after reset.
    mode = TRIG_RISE; offset = 32'd0;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      arm_i = (c >= 1); trigger_now_i = (c == 5); reset_i = (c == 10); stop = 1'b0;
      @(negedge clk);
      if (c == 6)  check("rst go before", go, 1);
      if (c == 10) check("rst go at assert", go, 1);
      if (c == 11) begin
        check("rst go", go, 0);
        check("rst armed", armed, 0);
        check("rst done", done, 0);
        check("rst count", cnt, 0);
        check("rst status", status, 0);
      end
      next_cyc();
    end
    reset_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
